// File: rtl/twiddle_rom_ifft.sv
// IFFT twiddle-factor responder.
// Returns W = exp(+j*2*pi*k/NFFT) three cycles after a valid address k.
// Only the quarter-wave cosine table C(0..NFFT/4) is stored. The other
// quadrants are derived by swapping and negating two table reads. An
// address-order checker raises a sticky seq_err, and frame_done marks
// the output for k = NFFT-1.
module twiddle_rom_ifft #(
  parameter int NFFT   = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Twiddle_valid,
  input  logic [ADDR_W-1:0]        Twiddle_address,
  output logic signed [DATA_W-1:0] Twiddle_re,
  output logic signed [DATA_W-1:0] Twiddle_im,
  output logic                     Twiddle_valid_out,
  output logic                     frame_done,
  output logic                     seq_err
);

  localparam int Q   = NFFT / 4;
  localparam int R_W = ADDR_W - 2;  // offset within a quadrant
  localparam int T_W = ADDR_W - 1;  // table index, covers 0..Q

  // Elaboration-time quarter-wave cosine, scaled to Q1.(DATA_W-1).
  // The Taylor series converges to full double precision on [0, pi/2].
  // The angle is never past pi/2, so the value is never below zero and a
  // plain +0.5 gives rounding half away from zero.
  function automatic logic signed [DATA_W-1:0] cos_q(input int m);
    real x;
    real term;
    real sum;
    real scaled;
    x    = 2.0 * 3.14159265358979323846 * m / NFFT;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 20; n++) begin
      term = -term * x * x / ((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scaled = sum * ((2.0 ** (DATA_W - 1)) - 1.0);
    return DATA_W'($rtoi(scaled + 0.5));
  endfunction

  // NOTE: the table holds constants, so it has no reset. Only the pipeline
  // state around it is cleared.
  logic signed [DATA_W-1:0] tab [0:Q];

  for (genvar m = 0; m <= Q; m++) begin : g_tab
    localparam logic signed [DATA_W-1:0] C_M = cos_q(m);
    assign tab[m] = C_M;
  end

  // ---------------------------------------------------------------- S1
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;

  // S1: capture the address, and only on valid cycles so that a don't-care
  // address never reaches any state.
  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= Twiddle_valid;
      if (Twiddle_valid) s1_addr <= Twiddle_address;
    end
  end

  // --------------------------------------------------- sequence checker
  logic              prev_valid;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] next_addr;

  // Modulo-NFFT successor. The natural ADDR_W-bit wrap makes NFFT-1 -> 0 legal.
  assign next_addr = prev_addr + ADDR_W'(1);

  // Checker: within a run of consecutive valid cycles the address must step
  // by one. An idle cycle ends the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_valid <= 1'b0;
      prev_addr  <= '0;
      seq_err    <= 1'b0;
    end else begin
      prev_valid <= s1_valid;
      if (s1_valid) prev_addr <= s1_addr;
      if (s1_valid && prev_valid && (s1_addr != next_addr)) seq_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [R_W-1:0]           r;
  logic [T_W-1:0]           idx_a;
  logic [T_W-1:0]           idx_b;
  logic                     s2_valid;
  logic [1:0]               s2_q;
  logic signed [DATA_W-1:0] s2_ca;   // C(r)
  logic signed [DATA_W-1:0] s2_cb;   // C(Q-r)
  logic                     s2_last;

  assign r     = s1_addr[R_W-1:0];
  assign idx_a = {1'b0, r};
  assign idx_b = T_W'(Q) - idx_a;

  // S2: read the two table entries and carry the quadrant forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
      s2_ca    <= '0;
      s2_cb    <= '0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_q     <= s1_addr[ADDR_W-1 -: 2];
      s2_ca    <= tab[idx_a];
      s2_cb    <= tab[idx_b];
      s2_last  <= (s1_addr == ADDR_W'(NFFT - 1));
    end
  end

  // ---------------------------------------------------------------- S3
  logic signed [DATA_W-1:0] fold_re;
  logic signed [DATA_W-1:0] fold_im;

  // Quadrant folding: swap and negate the two reads for quadrant q.
  // NOTE: the outputs get defaults before the case, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    fold_re = '0;
    fold_im = '0;
    case (s2_q)
      2'd0: begin fold_re =  s2_ca; fold_im =  s2_cb; end
      2'd1: begin fold_re = -s2_cb; fold_im =  s2_ca; end
      2'd2: begin fold_re = -s2_ca; fold_im = -s2_cb; end
      default: begin fold_re = s2_cb; fold_im = -s2_ca; end
    endcase
  end

  // S3: register the result. Outputs are zero on any slot that is not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Twiddle_valid_out <= 1'b0;
      Twiddle_re        <= '0;
      Twiddle_im        <= '0;
      frame_done        <= 1'b0;
    end else begin
      Twiddle_valid_out <= s2_valid;
      Twiddle_re        <= s2_valid ? fold_re : '0;
      Twiddle_im        <= s2_valid ? fold_im : '0;
      frame_done        <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_twiddle_rom_ifft.sv
// Self-checking bench for twiddle_rom_ifft.
// It combines a table of exact lookups, a cycle-by-cycle reference model
// (exp(+j*2*pi*k/N) from $cos/$sin, a 3-deep input history and a sticky
// order checker), directed corner sequences and a randomized run.
module tb_twiddle_rom_ifft;

  localparam int    NFFT   = 64;
  localparam int    ADDR_W = 6;
  localparam int    DATA_W = 16;
  localparam real   PI     = 3.14159265358979323846;
  localparam real   AMP    = 32767.0;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     Twiddle_valid = 1'b0;
  logic [ADDR_W-1:0]        Twiddle_address = '0;
  logic signed [DATA_W-1:0] Twiddle_re;
  logic signed [DATA_W-1:0] Twiddle_im;
  logic                     Twiddle_valid_out;
  logic                     frame_done;
  logic                     seq_err;

  twiddle_rom_ifft #(.NFFT(NFFT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .Twiddle_valid    (Twiddle_valid),
    .Twiddle_address  (Twiddle_address),
    .Twiddle_re       (Twiddle_re),
    .Twiddle_im       (Twiddle_im),
    .Twiddle_valid_out(Twiddle_valid_out),
    .frame_done       (frame_done),
    .seq_err          (seq_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    n_cmp++;
    if (act > exp + 1 || act < exp - 1) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (+/-1)", name, act, exp);
    end
  endtask

  // ------------------------------------------------ reference model
  typedef struct { bit v; int k; } in_t;
  in_t hist[$];
  bit  m_prev_v;
  int  m_prev_k;
  bit  m_err;
  int  fd_count;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_re(input int k);
    return rnd($cos(2.0 * PI * k / NFFT) * AMP);
  endfunction

  function automatic int ref_im(input int k);
    return rnd($sin(2.0 * PI * k / NFFT) * AMP);
  endfunction

  task automatic model_reset();
    in_t idle;
    idle.v = 1'b0;
    idle.k = 0;
    hist.delete();
    hist.push_back(idle);
    hist.push_back(idle);
    m_prev_v = 1'b0;
    m_prev_k = 0;
    m_err    = 1'b0;
  endtask

  // One clock cycle. Drive the inputs, let the edge pass, then compare every
  // output with the model. The output after an edge reflects the input from
  // two edges earlier. seq_err reflects the inputs up to the previous edge.
  task automatic cycle(input bit v, input int k);
    in_t cur;
    in_t e;
    bit  exp_err;
    Twiddle_valid   = v;
    Twiddle_address = ADDR_W'(k);
    @(posedge clk);
    #1;
    cur.v = v;
    cur.k = k;
    hist.push_back(cur);
    if (hist.size() > 3) void'(hist.pop_front());
    e       = hist[0];
    exp_err = m_err;
    if (v && m_prev_v && (k != (m_prev_k + 1) % NFFT)) m_err = 1'b1;
    m_prev_v = v;
    if (v) m_prev_k = k;
    check("valid_out", int'(Twiddle_valid_out), int'(e.v));
    check_near("re", int'(Twiddle_re), e.v ? ref_re(e.k) : 0);
    check_near("im", int'(Twiddle_im), e.v ? ref_im(e.k) : 0);
    check("frame_done", int'(frame_done), int'(e.v && e.k == NFFT - 1));
    check("seq_err", int'(seq_err), int'(exp_err));
    fd_count += int'(frame_done);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(Twiddle_valid_out), 0);
    check({tag, "_re"}, int'(Twiddle_re), 0);
    check({tag, "_im"}, int'(Twiddle_im), 0);
    check({tag, "_fd"}, int'(frame_done), 0);
    check({tag, "_seq"}, int'(seq_err), 0);
  endtask

  typedef struct { int k; int re; int im; bit fd; } vec_t;
  vec_t vecs [5];

  initial begin
    int nxt;
    vecs[0] = '{k: 0,  re: 32767,  im: 0,      fd: 1'b0};
    vecs[1] = '{k: 8,  re: 23170,  im: 23170,  fd: 1'b0};
    vecs[2] = '{k: 16, re: 0,      im: 32767,  fd: 1'b0};
    vecs[3] = '{k: 40, re: -23170, im: -23170, fd: 1'b0};
    vecs[4] = '{k: 63, re: 32609,  im: -3212,  fd: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    model_reset();

    // Single lookups at latency 3, exact table values, then idle zeros
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].k);
      cycle(1'b0, 0);
      cycle(1'b0, 0);
      check($sformatf("lut%0d_valid", vecs[i].k), int'(Twiddle_valid_out), 1);
      check($sformatf("lut%0d_re", vecs[i].k), int'(Twiddle_re), vecs[i].re);
      check($sformatf("lut%0d_im", vecs[i].k), int'(Twiddle_im), vecs[i].im);
      check($sformatf("lut%0d_fd", vecs[i].k), int'(frame_done), int'(vecs[i].fd));
      cycle(1'b0, 0);
      check($sformatf("lut%0d_idle", vecs[i].k), int'(Twiddle_valid_out), 0);
    end

    // Full frame back to back
    fd_count = 0;
    for (int k = 0; k < NFFT; k++) cycle(1'b1, k);
    repeat (4) cycle(1'b0, 0);
    check("burst_frame_done_count", fd_count, 1);
    check("burst_seq_err", int'(seq_err), 0);

    // Legal wrap, then an order violation that stays sticky through a gap
    for (int k = 61; k < 66; k++) cycle(1'b1, k % NFFT);
    repeat (2) cycle(1'b0, 0);
    check("wrap_seq_err", int'(seq_err), 0);
    cycle(1'b1, 5);
    cycle(1'b1, 7);
    repeat (3) cycle(1'b0, 0);
    check("skip_seq_err", int'(seq_err), 1);
    cycle(1'b1, 20);
    repeat (3) cycle(1'b0, 0);
    check("sticky_seq_err", int'(seq_err), 1);

    // Reset in the middle of a burst clears everything immediately
    for (int k = 20; k <= 22; k++) cycle(1'b1, k);
    Twiddle_valid   = 1'b1;
    Twiddle_address = ADDR_W'(23);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    Twiddle_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (6) cycle(1'b0, 0);
    check("post_rst_valid", int'(Twiddle_valid_out), 0);

    // A gap restarts the order check
    cycle(1'b1, 10);
    cycle(1'b0, 0);
    cycle(1'b1, 30);
    repeat (4) cycle(1'b0, 0);
    check("gap_restart_seq_err", int'(seq_err), 0);

    // Randomized traffic: mostly sequential, with occasional jumps and gaps
    nxt = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cycle(1'b0, int'($urandom_range(0, NFFT - 1)));
      end else begin
        if ($urandom_range(0, 24) == 0) nxt = int'($urandom_range(0, NFFT - 1));
        cycle(1'b1, nxt);
        nxt = (nxt + 1) % NFFT;
      end
    end
    repeat (4) cycle(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle_rom_ifft.md
Name: twiddle_rom_ifft

Overview:
- Responder for the IFFT twiddle-address interface.
- Accepts a stream of twiddle addresses k (0..NFFT-1) from a stage address generator.
- Returns the registered IFFT twiddle factor W = exp(+j·2πk/NFFT) as signed fixed-point real/imag. It stores only a quarter-wave cosine table and derives the other quadrants.
- Sits between the stage address generator and the complex multiplier of that stage. It also flags address-sequence breaks and marks the end of each frame.

Parameters:
- NFFT, 64, transform size; must be a power of two, ≥8.
- ADDR_W, 6, address width; equals log2(NFFT).
- DATA_W, 16, twiddle component width, signed Q1.(DATA_W-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- Twiddle_valid  input  1  Twiddle_address is meaningful this cycle.
- Twiddle_address  input  ADDR_W  twiddle index k.
- Twiddle_re  output  DATA_W  signed real part of W.
- Twiddle_im  output  DATA_W  signed imaginary part of W.
- Twiddle_valid_out  output  1  Twiddle_re/Twiddle_im valid.
- frame_done  output  1  one-cycle pulse aligned with the output for k = NFFT-1.
- seq_err  output  1  sticky; set on an address-order violation.

Behaviour:
- Reset:
  - rst=0 clears all pipeline registers immediately, asynchronously.
  - Twiddle_re=0, Twiddle_im=0, Twiddle_valid_out=0, frame_done=0, seq_err=0.
  - Any in-flight lookups are discarded; no output valid appears for them after reset release.
- Table:
  - C(m) = round(cos(2πm/NFFT)·(2^(DATA_W-1)-1)), for m = 0..NFFT/4, rounding half away from zero.
  - NFFT/4+1 entries.
  - For NFFT=64, DATA_W=16: C(0)=32767, C(1)=32609, C(8)=23170, C(15)=3212, C(16)=0.
- Folding: q = k[ADDR_W-1:ADDR_W-2], r = k[ADDR_W-3:0], Q = NFFT/4.
  - q=0: re = C(r), im = C(Q-r)
  - q=1: re = -C(Q-r), im = C(r)
  - q=2: re = -C(r), im = -C(Q-r)
  - q=3: re = C(Q-r), im = -C(r)
  - Negation is two's complement. -0 yields 0. No value exceeds ±(2^(DATA_W-1)-1), so no saturation is needed.
- Pipeline: 3 register stages, fixed latency 3.
  - S1 registers address and valid.
  - S2 registers the two table reads plus q.
  - S3 registers the signed/swapped result.
  - Input valid in cycle n produces Twiddle_valid_out=1 in cycle n+3. Throughput is one address per cycle; there is no backpressure.
- Output when idle: when Twiddle_valid_out=0, Twiddle_re and Twiddle_im are driven 0. Table results for invalid slots are never exposed.
- frame_done: asserted together with Twiddle_valid_out for an output whose k = NFFT-1.
- Sequence checker, operating on the S1 stage:
  - Tracks the last valid address and a flag "prev_valid" (previous cycle valid).
  - If the current and previous cycles are both valid and addr ≠ (prev_addr+1) mod NFFT, seq_err is set and stays set until reset.
  - A cycle with Twiddle_valid=0 clears prev_valid, so a new burst may start at any address.
  - Wrap NFFT-1 → 0 in consecutive cycles is legal.
- Twiddle_address is don't-care when Twiddle_valid=0 and has no effect on any state.

Test Plan:
1. Reset, then a single valid k=0 at cycle n → cycle n+3: Twiddle_valid_out=1, re=32767, im=0, frame_done=0. Cycle n+4: valid_out=0, re=im=0.
2. Individual lookups:
   - k=8 → (23170, 23170)
   - k=16 → (0, 32767)
   - k=40 → (-23170, -23170)
   - k=63 → (32609, -3212), with frame_done=1 on that output cycle
   - all at latency 3
3. Continuous burst k=0..63 back-to-back → 64 consecutive valid outputs matching a reference exp(+j2πk/64) model within ±1 LSB; exactly one frame_done, on the last; seq_err stays 0.
4. Burst 61,62,63,0,1 → seq_err stays 0. Then consecutive 5,7 → seq_err=1 and stays 1. A one-cycle gap followed by 20 does not clear it.
5. Gap restart: valid 10, invalid cycle, valid 30 → seq_err=0.
6. Reset mid-burst: drive k=20..25, assert rst=0 one cycle after k=22 is sampled → all outputs 0 immediately. After release with no input, Twiddle_valid_out remains 0 for ≥5 cycles.
